// File: rtl/mtimer_pkg.sv
// Shared register map, control-bit index and reset default for the machine timer.
// Also holds the byte-strobe merge used by every writable register.
package mtimer_pkg;

    localparam logic [4:0] ADDR_CR        = 5'h00;
    localparam logic [4:0] ADDR_MTIMEL    = 5'h04;
    localparam logic [4:0] ADDR_MTIMEH    = 5'h08;
    localparam logic [4:0] ADDR_MTIMECMPL = 5'h0C;
    localparam logic [4:0] ADDR_MTIMECMPH = 5'h10;
    localparam logic [4:0] ADDR_PRESC     = 5'h14;

    localparam int CR_EN = 0;

    localparam logic [63:0] DEFAULT_RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] apply_strobe(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strobe
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strobe[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator: pulses once every presc+1 enabled cycles; combinational tick, no backpressure.
// Counter holds while disabled and restarts from 0 when the divisor is rewritten.
module mtimer_prescaler (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] presc,
    input  logic        clear,
    output logic        tick
);

    logic [15:0] count;

    assign tick = enable && (count == presc);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable) begin
            count <= tick ? 16'd0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with level irq_timer; prescaler under MTIMER_PRESCALER_EN.
// Latency: read/write acks one cycle after request, irq one cycle after condition; never stalls.
module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [63:0] RESET_MTIMECMP = DEFAULT_RESET_MTIMECMP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    input  logic        write_request,
    output logic        write_response,
    output logic        irq_timer
);

    logic [4:0]  reg_addr;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_nxt;
    logic [31:0] rd_mux;
    logic        cr_en;
    logic        tick;
    logic        wr_cr, wr_mtimel, wr_mtimeh, wr_cmpl, wr_cmph;
    logic        unused_addr_bits;

    // Word-aligned offset; the bus has already decoded the upper address bits.
    assign reg_addr         = {rw_address[4:2], 2'b00};
    assign unused_addr_bits = ^{rw_address[31:5], rw_address[1:0]};

    assign wr_cr     = write_request && (reg_addr == ADDR_CR);
    assign wr_mtimel = write_request && (reg_addr == ADDR_MTIMEL);
    assign wr_mtimeh = write_request && (reg_addr == ADDR_MTIMEH);
    assign wr_cmpl   = write_request && (reg_addr == ADDR_MTIMECMPL);
    assign wr_cmph   = write_request && (reg_addr == ADDR_MTIMECMPH);

`ifdef MTIMER_PRESCALER_EN
    logic [15:0] presc;
    logic        wr_presc;

    assign wr_presc = write_request && (reg_addr == ADDR_PRESC);

    mtimer_prescaler u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (cr_en),
        .presc  (presc),
        .clear  (wr_presc),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= 16'd0;
        end else if (wr_presc) begin
            presc <= apply_strobe({16'd0, presc}, write_data, write_strobe) >> 0 & 32'h0000_FFFF;
        end
    end
`else
    assign tick = cr_en;
`endif

    assign mtime_inc = tick ? mtime + 64'd1 : mtime;

    // A software write overrides only its strobed bytes; everything else keeps the increment.
    always_comb begin
        mtime_nxt = mtime_inc;
        if (wr_mtimel) begin
            mtime_nxt[31:0] = apply_strobe(mtime_inc[31:0], write_data, write_strobe);
        end
        if (wr_mtimeh) begin
            mtime_nxt[63:32] = apply_strobe(mtime_inc[63:32], write_data, write_strobe);
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (reg_addr)
            ADDR_CR:        rd_mux = {31'd0, cr_en};
            ADDR_MTIMEL:    rd_mux = mtime[31:0];
            ADDR_MTIMEH:    rd_mux = mtime[63:32];
            ADDR_MTIMECMPL: rd_mux = mtimecmp[31:0];
            ADDR_MTIMECMPH: rd_mux = mtimecmp[63:32];
`ifdef MTIMER_PRESCALER_EN
            ADDR_PRESC:     rd_mux = {16'd0, presc};
`endif
            default:        rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime          <= 64'd0;
            mtimecmp       <= RESET_MTIMECMP;
            cr_en          <= 1'b0;
            read_data      <= 32'd0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
            irq_timer      <= 1'b0;
        end else begin
            mtime          <= mtime_nxt;
            read_response  <= read_request;
            write_response <= write_request;
            irq_timer      <= cr_en && (mtime >= mtimecmp);
            if (read_request) begin
                read_data <= rd_mux;
            end
            if (wr_cr && write_strobe[0]) begin
                cr_en <= write_data[CR_EN];
            end
            if (wr_cmpl) begin
                mtimecmp[31:0] <= apply_strobe(mtimecmp[31:0], write_data, write_strobe);
            end
            if (wr_cmph) begin
                mtimecmp[63:32] <= apply_strobe(mtimecmp[63:32], write_data, write_strobe);
            end
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register-map table plus timed sequences for counting, wrap, irq and reset.
module tb_mtimer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rw_address = 32'd0;
    logic [31:0] read_data;
    logic        read_request = 1'b0;
    logic        read_response;
    logic [31:0] write_data = 32'd0;
    logic [3:0]  write_strobe = 4'd0;
    logic        write_request = 1'b0;
    logic        write_response;
    logic        irq_timer;

    int n_vec  = 0;
    int n_fail = 0;

    mtimer dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .irq_timer      (irq_timer)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one request cycle starting now (just after an edge); returns 1ns after the commit edge.
    task automatic bus(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
        rw_address    = {24'd0, addr};
        read_request  = rd;
        write_request = wr;
        write_data    = wd;
        write_strobe  = st;
        @(posedge clock);
        #1;
        read_request  = 1'b0;
        write_request = 1'b0;
        write_strobe  = 4'd0;
    endtask

    task automatic wr32(input logic [7:0] addr, input logic [31:0] data);
        bus(1'b0, 1'b1, addr, data, 4'hF);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        bus(1'b1, 1'b0, addr, 32'd0, 4'd0);
        check(name, read_data, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic irq_chk(input string name, input logic exp);
        check(name, {31'd0, irq_timer}, {31'd0, exp});
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] presc_exp;
`ifdef MTIMER_PRESCALER_EN
        presc_exp = 32'h7;
`else
        presc_exp = 32'h0;
`endif
        tbl[0]  = mk(1, 0, 8'h0C, 32'h0,          4'h0, 32'hFFFF_FFFF);
        tbl[1]  = mk(1, 0, 8'h10, 32'h0,          4'h0, 32'hFFFF_FFFF);
        tbl[2]  = mk(1, 0, 8'h00, 32'h0,          4'h0, 32'h0);
        tbl[3]  = mk(1, 0, 8'h04, 32'h0,          4'h0, 32'h0);
        tbl[4]  = mk(1, 1, 8'h0C, 32'hAABB_CCDD, 4'h5, 32'hFFFF_FFFF);
        tbl[5]  = mk(1, 0, 8'h0C, 32'h0,          4'h0, 32'hFFBB_FFDD);
        tbl[6]  = mk(1, 0, 8'h0F, 32'h0,          4'h0, 32'hFFBB_FFDD);
        tbl[7]  = mk(0, 1, 8'h10, 32'h1122_3344, 4'h8, 32'h0);
        tbl[8]  = mk(1, 0, 8'h10, 32'h0,          4'h0, 32'h11FF_FFFF);
        tbl[9]  = mk(0, 1, 8'h18, 32'hDEAD_BEEF, 4'hF, 32'h0);
        tbl[10] = mk(1, 0, 8'h18, 32'h0,          4'h0, 32'h0);
        tbl[11] = mk(0, 1, 8'h00, 32'hFFFF_FFFF, 4'hE, 32'h0);
        tbl[12] = mk(1, 0, 8'h00, 32'h0,          4'h0, 32'h0);
        tbl[13] = mk(0, 1, 8'h14, 32'h0000_0007, 4'hF, 32'h0);
        tbl[14] = mk(1, 0, 8'h14, 32'h0,          4'h0, presc_exp);
        tbl[15] = mk(0, 1, 8'h14, 32'h0,          4'hF, 32'h0);

        repeat (3) @(posedge clock);
        #1;
        check("reset read_data", read_data, 32'd0);
        check("reset read_response", {31'd0, read_response}, 32'd0);
        check("reset write_response", {31'd0, write_response}, 32'd0);
        irq_chk("reset irq", 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            prev = read_data;
            bus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
            check($sformatf("vec%0d read_response", i), {31'd0, read_response}, {31'd0, tbl[i].rd});
            check($sformatf("vec%0d write_response", i), {31'd0, write_response}, {31'd0, tbl[i].wr});
            check($sformatf("vec%0d read_data", i), read_data, tbl[i].rd ? tbl[i].exp : prev);
            irq_chk($sformatf("vec%0d irq", i), 1'b0);
        end

        // Counting: enable takes effect the cycle after the CR write.
        wr32(8'h00, 32'h1);
        idle(10);
        rd_chk("count +10", 8'h04, 32'd10);
        rd_chk("count +11", 8'h04, 32'd11);
        wr32(8'h00, 32'h0);
        rd_chk("frozen a", 8'h04, 32'd13);
        idle(5);
        rd_chk("frozen b", 8'h04, 32'd13);
        rd_chk("frozen high", 8'h08, 32'd0);

        // Low-to-high carry, then full 64-bit wrap.
        wr32(8'h04, 32'hFFFF_FFFE);
        wr32(8'h08, 32'h0);
        wr32(8'h00, 32'h1);
        idle(2);
        rd_chk("carry low", 8'h04, 32'd0);
        rd_chk("carry high", 8'h08, 32'd1);
        wr32(8'h00, 32'h0);
        wr32(8'h04, 32'hFFFF_FFFF);
        wr32(8'h08, 32'hFFFF_FFFF);
        wr32(8'h00, 32'h1);
        rd_chk("allones high", 8'h08, 32'hFFFF_FFFF);
        rd_chk("wrap low", 8'h04, 32'd0);
        rd_chk("wrap high", 8'h08, 32'd0);

        // Writing the high word while the low word carries out.
        wr32(8'h00, 32'h0);
        wr32(8'h04, 32'hFFFF_FFFE);
        wr32(8'h08, 32'h0);
        wr32(8'h00, 32'h1);
        idle(1);
        wr32(8'h08, 32'h5);
        rd_chk("wrhigh low", 8'h04, 32'd0);
        rd_chk("wrhigh high", 8'h08, 32'd5);

        // Single-byte write while counting.
        wr32(8'h00, 32'h0);
        wr32(8'h04, 32'h0);
        wr32(8'h08, 32'h0);
        wr32(8'h00, 32'h1);
        idle(3);
        bus(1'b0, 1'b1, 8'h04, 32'h1234_5678, 4'b0010);
        check("strobe write_response", {31'd0, write_response}, 32'd1);
        rd_chk("strobe low", 8'h04, 32'h0000_5604);
        rd_chk("strobe high", 8'h08, 32'd0);

        // Interrupt timing relative to enable, compare update and EN clear.
        wr32(8'h00, 32'h0);
        wr32(8'h04, 32'h0);
        wr32(8'h08, 32'h0);
        wr32(8'h10, 32'h0);
        wr32(8'h0C, 32'h20);
        wr32(8'h00, 32'h1);
        idle(32'h20);
        irq_chk("irq before", 1'b0);
        idle(1);
        irq_chk("irq rise", 1'b1);
        wr32(8'h0C, 32'h1000);
        irq_chk("irq lag", 1'b1);
        idle(1);
        irq_chk("irq fall cmp", 1'b0);
        wr32(8'h0C, 32'h0);
        idle(1);
        irq_chk("irq cmp zero", 1'b1);
        wr32(8'h00, 32'h0);
        idle(1);
        irq_chk("irq fall en", 1'b0);

`ifdef MTIMER_PRESCALER_EN
        wr32(8'h04, 32'h0);
        wr32(8'h08, 32'h0);
        wr32(8'h14, 32'h3);
        wr32(8'h00, 32'h1);
        idle(3);
        rd_chk("presc cyc3", 8'h04, 32'd0);
        rd_chk("presc cyc4", 8'h04, 32'd1);
        idle(3);
        rd_chk("presc cyc8", 8'h04, 32'd2);
        wr32(8'h00, 32'h0);
`endif

        // Unsigned compare: a top-bit-set mtime is above compare value 1.
        wr32(8'h00, 32'h0);
        wr32(8'h08, 32'h8000_0000);
        wr32(8'h04, 32'h0);
        wr32(8'h10, 32'h0);
        wr32(8'h0C, 32'h1);
        wr32(8'h00, 32'h1);
        idle(2);
        irq_chk("irq unsigned", 1'b1);
        rd_chk("unsigned high", 8'h08, 32'h8000_0000);

        // Reset while counting, with a read in flight.
        rw_address   = 32'h4;
        read_request = 1'b1;
        reset        = 1'b1;
        @(posedge clock);
        #1;
        reset        = 1'b0;
        read_request = 1'b0;
        check("rst read_response", {31'd0, read_response}, 32'd0);
        check("rst read_data", read_data, 32'd0);
        irq_chk("rst irq", 1'b0);
        idle(2);
        rd_chk("rst cr", 8'h00, 32'd0);
        rd_chk("rst mtimel", 8'h04, 32'd0);
        rd_chk("rst mtimeh", 8'h08, 32'd0);
        rd_chk("rst cmpl", 8'h0C, 32'hFFFF_FFFF);
        rd_chk("rst cmph", 8'h10, 32'hFFFF_FFFF);
        rd_chk("rst presc", 8'h14, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
